// File: rtl/wb_cpu_arbiter_if.sv
// Bundles the two CPU-side wishbone masters (DCMU = index 0, ICMU = index 1)
// and the single shared wishbone bus handled by wb_cpu_arbiter.
//   m_*  : per-master request fields (packed, master 0 in the low slice),
//          shared read data, per-master ack and timeout-error pulses.
//   s_*  : shared-bus request fields, plus read data and ack from the slave.
// Modport slave is the arbiter's view of the CPU masters.
// Modport master is the arbiter's view of the shared bus.
interface wb_cpu_arbiter_if;
  logic [1:0]  m_cyc_i;
  logic [1:0]  m_stb_i;
  logic [59:0] m_addr_i;
  logic [5:0]  m_cti_i;
  logic [3:0]  m_bte_i;
  logic [7:0]  m_sel_i;
  logic [1:0]  m_we_i;
  logic [63:0] m_data_i;
  logic [31:0] m_data_o;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_err_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:2] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_addr_i, m_cti_i, m_bte_i, m_sel_i, m_we_i, m_data_i,
    output m_data_o, m_ack_o, m_err_o
  );

  modport master (
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o, s_data_o,
    input  s_data_i, s_ack_i
  );
endinterface

// File: rtl/wb_cpu_arbiter.sv
// Two-master wishbone arbiter sharing one bus between the DCMU (master 0)
// and the ICMU (master 1).
//   clk  : single clock for all logic
//   rst  : synchronous, active-high reset
//   cpu  : CPU-side masters (wb_cpu_arbiter_if.slave)
//   bus  : shared wishbone bus (wb_cpu_arbiter_if.master)
// Parameter TIMEOUT (1..65535): stalled strobe cycles tolerated before the
// transfer is aborted and the owner receives a one-cycle m_err_o pulse.
// A grant lasts until the owner drops m_cyc_i; ties go to the master that
// did not win last time. One dead IDLE cycle separates consecutive owners.
module wb_cpu_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  wb_cpu_arbiter_if.slave   cpu,
  wb_cpu_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q,  last_d;
  logic [15:0] stall_q, stall_d;
  logic [1:0]  err_q,   err_d;

  logic        own_cyc, own_stb, own_we;
  logic [29:0] own_addr;
  logic [2:0]  own_cti;
  logic [1:0]  own_bte;
  logic [3:0]  own_sel;
  logic [31:0] own_data;
  logic        in_own;
  logic        stalled;
  logic        winner;

  // Current owner's request fields.
  always_comb begin
    own_cyc  = cpu.m_cyc_i[owner_q];
    own_stb  = cpu.m_stb_i[owner_q];
    own_we   = cpu.m_we_i[owner_q];
    own_addr = owner_q ? cpu.m_addr_i[59:30] : cpu.m_addr_i[29:0];
    own_cti  = owner_q ? cpu.m_cti_i[5:3]    : cpu.m_cti_i[2:0];
    own_bte  = owner_q ? cpu.m_bte_i[3:2]    : cpu.m_bte_i[1:0];
    own_sel  = owner_q ? cpu.m_sel_i[7:4]    : cpu.m_sel_i[3:0];
    own_data = owner_q ? cpu.m_data_i[63:32] : cpu.m_data_i[31:0];
  end

  assign in_own = (state_q == OWN);

  // Shared-bus outputs follow the owner only while it holds the bus.
  always_comb begin
    bus.s_cyc_o  = in_own & own_cyc;
    bus.s_stb_o  = in_own & own_stb;
    bus.s_we_o   = in_own & own_we;
    bus.s_addr_o = in_own ? own_addr : '0;
    bus.s_cti_o  = in_own ? own_cti  : '0;
    bus.s_bte_o  = in_own ? own_bte  : '0;
    bus.s_sel_o  = in_own ? own_sel  : '0;
    bus.s_data_o = in_own ? own_data : '0;
  end

  // Ack is suppressed during reset so an interrupted transfer completes
  // neither with an ack nor with an error.
  always_comb begin
    cpu.m_data_o = bus.s_data_i;
    cpu.m_ack_o  = '0;
    if (in_own && !rst) cpu.m_ack_o[owner_q] = bus.s_ack_i;
    cpu.m_err_o  = err_q;
  end

  assign stalled = (in_own & own_stb) & ~bus.s_ack_i;
  assign winner  = (cpu.m_cyc_i == 2'b11) ? ~last_q : cpu.m_cyc_i[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    stall_d = stall_q;
    err_d   = '0;

    if (stalled) begin
      if (stall_q != '1) stall_d = stall_q + 16'd1;
    end else begin
      stall_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (|cpu.m_cyc_i) begin
          owner_d = winner;
          last_d  = winner;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!own_cyc) begin
          state_d = IDLE;
        // Abort on the edge where the stall count reaches TIMEOUT; an ack
        // in that cycle clears "stalled", so the ack wins.
        end else if (stalled && ({1'b0, stall_q} + 17'd1 >= 17'(TIMEOUT))) begin
          err_d[owner_q] = 1'b1;
          state_d        = ABORT;
        end
      end
      ABORT: begin
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_cpu_arbiter.sv
module tb_wb_cpu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  wb_cpu_arbiter_if bus_if();

  wb_cpu_arbiter #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (bus_if),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int unsigned i, input logic cyc, input logic stb,
                       input logic [29:0] addr, input logic [2:0] cti, input logic we,
                       input logic [31:0] data);
    bus_if.m_cyc_i[i]          = cyc;
    bus_if.m_stb_i[i]          = stb;
    bus_if.m_addr_i[i*30 +: 30] = addr;
    bus_if.m_cti_i[i*3 +: 3]   = cti;
    bus_if.m_bte_i[i*2 +: 2]   = 2'b00;
    bus_if.m_sel_i[i*4 +: 4]   = 4'hF;
    bus_if.m_we_i[i]           = we;
    bus_if.m_data_i[i*32 +: 32] = data;
  endtask

  task automatic release_m(input int unsigned i);
    drive(i, 1'b0, 1'b0, '0, 3'b000, 1'b0, '0);
  endtask

  initial begin
    bus_if.m_cyc_i  = '0;
    bus_if.m_stb_i  = '0;
    bus_if.m_addr_i = '0;
    bus_if.m_cti_i  = '0;
    bus_if.m_bte_i  = '0;
    bus_if.m_sel_i  = '0;
    bus_if.m_we_i   = '0;
    bus_if.m_data_i = '0;
    bus_if.s_data_i = '0;
    bus_if.s_ack_i  = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_s_cyc", bus_if.s_cyc_o, 0);
    check("rst_s_addr", bus_if.s_addr_o, 0);
    check("rst_err", bus_if.m_err_o, 0);
    rst = 1'b0;

    // Single DCMU read at byte 0x100 (word 0x40), ack on the 4th bus cycle
    drive(0, 1'b1, 1'b1, 30'h40, 3'b000, 1'b0, 32'h0);
    settle();
    check("t1_latency0", bus_if.s_cyc_o, 0);
    tick();
    check("t1_s_cyc", bus_if.s_cyc_o, 1);
    check("t1_s_addr", bus_if.s_addr_o, 30'h40);
    check("t1_s_we", bus_if.s_we_o, 0);
    check("t1_no_ack", bus_if.m_ack_o, 2'b00);
    tick(); tick();
    bus_if.s_ack_i  = 1'b1;
    bus_if.s_data_i = 32'hCAFEBABE;
    settle();
    check("t1_ack", bus_if.m_ack_o, 2'b01);
    check("t1_data", bus_if.m_data_o, 32'hCAFEBABE);
    tick();
    bus_if.s_ack_i = 1'b0;
    release_m(0);
    settle();
    check("t1_drop", bus_if.s_cyc_o, 0);
    tick(); tick();

    // Simultaneous request from reset: DCMU first
    rst = 1'b1; tick(); rst = 1'b0;
    drive(0, 1'b1, 1'b1, 30'h300, 3'b000, 1'b1, 32'h11112222);
    drive(1, 1'b1, 1'b1, 30'h200, 3'b010, 1'b0, 32'h0);
    tick();
    check("t2_first_addr", bus_if.s_addr_o, 30'h300);
    check("t2_first_we", bus_if.s_we_o, 1);
    check("t2_first_data", bus_if.s_data_o, 32'h11112222);
    bus_if.s_ack_i = 1'b1;
    settle();
    check("t2_ack_d", bus_if.m_ack_o, 2'b01);
    tick();
    bus_if.s_ack_i = 1'b0;
    drive(0, 1'b0, 1'b0, 30'h300, 3'b000, 1'b1, 32'h11112222);
    settle();
    check("t2_drop", bus_if.s_cyc_o, 0);
    tick();
    check("t2_dead", bus_if.s_cyc_o, 0);
    // DCMU requests again while ICMU is granted and runs its burst
    drive(0, 1'b1, 1'b1, 30'h300, 3'b000, 1'b0, 32'h0);
    tick();
    check("t2_icmu_cyc", bus_if.s_cyc_o, 1);
    check("t2_icmu_addr", bus_if.s_addr_o, 30'h200);

    // ICMU 4-beat incrementing burst, all acks to ICMU
    for (int b = 0; b < 4; b++) begin
      bus_if.m_addr_i[59:30] = 30'h200 + 30'(b);
      bus_if.m_cti_i[5:3]    = (b == 3) ? 3'b111 : 3'b010;
      bus_if.s_ack_i         = 1'b1;
      settle();
      check("t3_burst_ack", bus_if.m_ack_o, 2'b10);
      check("t3_burst_cti", bus_if.s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    bus_if.s_ack_i = 1'b0;
    release_m(1);
    settle();
    check("t3_drop", bus_if.s_cyc_o, 0);
    tick();
    check("t3_dead", bus_if.s_cyc_o, 0);
    tick();
    check("t3_dcmu_cyc", bus_if.s_cyc_o, 1);
    check("t3_dcmu_addr", bus_if.s_addr_o, 30'h300);
    bus_if.s_ack_i = 1'b1;
    tick();
    bus_if.s_ack_i = 1'b0;
    release_m(0);
    tick(); tick();

    // Timeout: slave never acks; abort after 8 stalled cycles
    drive(0, 1'b1, 1'b1, 30'h55, 3'b000, 1'b0, 32'h0);
    tick();
    check("t4_cyc", bus_if.s_cyc_o, 1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("t4_no_err", bus_if.m_err_o, 2'b00);
    end
    check("t4_cyc_before", bus_if.s_cyc_o, 1);
    tick();
    check("t4_err", bus_if.m_err_o, 2'b01);
    check("t4_abort_cyc", bus_if.s_cyc_o, 0);
    check("t4_abort_stb", bus_if.s_stb_o, 0);
    bus_if.s_ack_i = 1'b1;
    settle();
    check("t4_abort_noack", bus_if.m_ack_o, 2'b00);
    tick();
    bus_if.s_ack_i = 1'b0;
    check("t4_err_pulse", bus_if.m_err_o, 2'b00);
    check("t4_abort_hold", bus_if.s_cyc_o, 0);
    release_m(0);
    tick();
    // Back in IDLE: a fresh request is granted again
    drive(0, 1'b1, 1'b1, 30'h66, 3'b000, 1'b0, 32'h0);
    tick();
    check("t4_regrant", bus_if.s_cyc_o, 1);

    // Ack in the cycle the count would reach TIMEOUT: ack wins, no error
    for (int c = 2; c <= 8; c++) tick();
    bus_if.s_ack_i = 1'b1;
    settle();
    check("t5_late_ack", bus_if.m_ack_o, 2'b01);
    tick();
    bus_if.s_ack_i = 1'b0;
    check("t5_no_err", bus_if.m_err_o, 2'b00);
    check("t5_still_own", bus_if.s_cyc_o, 1);
    release_m(0);
    tick(); tick();

    // Reset during ICMU burst beat 2
    drive(1, 1'b1, 1'b1, 30'h400, 3'b010, 1'b0, 32'h0);
    tick();
    check("t6_icmu_grant", bus_if.s_addr_o, 30'h400);
    bus_if.s_ack_i = 1'b1;
    settle();
    check("t6_beat1", bus_if.m_ack_o, 2'b10);
    tick();
    rst = 1'b1;
    settle();
    check("t6_rst_noack", bus_if.m_ack_o, 2'b00);
    tick();
    rst = 1'b0;
    bus_if.s_ack_i = 1'b0;
    check("t6_rst_cyc", bus_if.s_cyc_o, 0);
    check("t6_rst_stb", bus_if.s_stb_o, 0);
    check("t6_rst_addr", bus_if.s_addr_o, 0);
    check("t6_rst_err", bus_if.m_err_o, 2'b00);
    drive(0, 1'b1, 1'b1, 30'h500, 3'b000, 1'b0, 32'h0);
    tick();
    check("t6_tie_dcmu", bus_if.s_addr_o, 30'h500);
    check("t6_tie_cyc", bus_if.s_cyc_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_cpu_arbiter.md
WB_CPU_ARBITER -- requirements
Module: wb_cpu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, range 1..65535; cycles of s_stb_o high without s_ack_i before the transfer is aborted.
REQ-002 Port clk  input  1  main clock; one clock for all logic.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port m_cyc_i  input  2  wishbone cycle per master; bit0 = DCMU, bit1 = ICMU.
REQ-005 Port m_stb_i  input  2  strobe per master.
REQ-006 Port m_addr_i  input  60  word address [31:2] per master; bits [29:0] = master 0.
REQ-007 Port m_cti_i  input  6  cycle type, 3 bits per master.
REQ-008 Port m_bte_i  input  4  burst type, 2 bits per master.
REQ-009 Port m_sel_i  input  8  byte select, 4 bits per master.
REQ-010 Port m_we_i  input  2  write enable per master.
REQ-011 Port m_data_i  input  64  write data, 32 bits per master.
REQ-012 Port m_data_o  output  32  read data, shared by both masters.
REQ-013 Port m_ack_o  output  2  acknowledge per master.
REQ-014 Port m_err_o  output  2  timeout error pulse per master.
REQ-015 Ports s_cyc_o, s_stb_o, s_we_o  output  1 each  shared-bus controls.
REQ-016 Ports s_addr_o [31:2], s_cti_o 3, s_bte_o 2, s_sel_o 4, s_data_o 32  output  shared-bus fields.
REQ-017 Ports s_data_i  input  32, s_ack_i  input  1  shared-bus read data and acknowledge.

Function
REQ-018 States: IDLE, OWN, ABORT; 1-bit owner register; 1-bit last-grant register; 16-bit stall counter.
REQ-019 IDLE: if any m_cyc_i is high, grant on the next edge and enter OWN; a single requester wins; if both request, the master other than last-grant wins.
REQ-020 On grant, owner and last-grant take the winner's index; arbitration latency is exactly 1 cycle from m_cyc_i high to s_cyc_o high.
REQ-021 OWN: s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o and s_data_o combinationally follow the owner's inputs.
REQ-022 Outside OWN, all s_* outputs are 0.
REQ-023 m_ack_o[owner] = s_ack_i in OWN only; the non-owner ack is always 0; m_data_o = s_data_i unconditionally.
REQ-024 The grant is held for the full cycle, including multi-beat bursts (cti 010), until the owner drops m_cyc_i.
REQ-025 OWN and owner m_cyc_i low: next state is IDLE; the new arbitration happens in IDLE, giving one dead cycle between owners.
REQ-026 Requests from the non-owner never preempt the owner.
REQ-027 Stall counter clears in any cycle where s_ack_i is high or s_stb_o is low, and increments otherwise; it saturates.
REQ-028 Counter reaching TIMEOUT in OWN: m_err_o[owner] pulses for 1 cycle, the state goes to ABORT, and s_cyc_o/s_stb_o drop on the next cycle.
REQ-029 An s_ack_i arriving in the same cycle the counter reaches TIMEOUT takes priority: the ack is delivered and no error is raised.
REQ-030 ABORT: all s_* are 0 and s_ack_i is ignored; the state returns to IDLE once owner m_cyc_i is low.
REQ-031 m_err_o is registered; at most one bit is high at a time.

Reset
REQ-032 rst is sampled on clk only; while high the state is IDLE, owner = 0, last-grant = 1 (master 0 wins the first tie), counter = 0, m_err_o = 0, and all s_* outputs = 0.
REQ-033 rst asserted mid-transfer drops s_cyc_o on the next edge with no m_ack_o or m_err_o; masters must restart.

Verification
REQ-034 Single DCMU read at 0x100, ack after 3 cycles -> s_cyc_o rises 1 cycle after m_cyc_i[0]; s_addr_o = 0x40; m_ack_o = 01 with m_data_o = s_data_i.
REQ-035 Both masters request simultaneously from reset -> DCMU is served first; after it drops cyc, one dead cycle, then ICMU is granted.
REQ-036 ICMU 4-beat incrementing burst (cti 010, 010, 010, 111) while DCMU requests -> all 4 acks go to ICMU; DCMU is granted only after ICMU cyc drops.
REQ-037 TIMEOUT=8, slave never acks DCMU -> m_err_o = 01 for exactly 1 cycle at the 8th stalled cycle; s_cyc_o = 0 next cycle; IDLE once m_cyc_i[0] falls.
REQ-038 rst pulsed during an ICMU burst beat 2 -> all s_* = 0 the next cycle; the next tie is won by DCMU.
